keypad_scan_decoder: RTL and testbench

//   Row-scanned matrix keypad controller. Drives one keypad row low at a time and

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_frame_debounce.sv | 100 ++++++++++
 rtl/keypad_scan_decoder.sv | 150 +++++++++++++++
 tb/tb_keypad_scan_decoder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the row-scanned keypad decoder.
// Frame classification, code-space sizing and the phone-style key map.
package keypad_pkg;

    typedef enum logic [1:0] {
        FR_NONE   = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } frame_res_t;

    function automatic int no_key(input int rows, input int cols);
        return rows * cols;
    endfunction

    function automatic int code_width(input int rows, input int cols);
        return $clog2(rows * cols + 1);
    endfunction

    // Phone layout on a 4x3 pad: 1..9 on rows 0-2, then '*'=10, 0, '#'=11.
    function automatic int legacy_code(input int r, input int c, input int rows, input int cols);
        if (rows != 4 || cols != 3) return r * cols + c;
        if (r < 3)                  return r * cols + c + 1;
        if (c == 0)                 return 10;
        if (c == 1)                 return 0;
        return 11;
    endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Whole-frame debouncer: promotes a frame result to the stable state after
// DEBOUNCE identical frames, with ghost guard and optional auto-repeat.
module keypad_frame_debounce
    import keypad_pkg::*;
#(
    parameter int CW         = 4,
    parameter int NO_KEY     = 12,
    parameter int DEBOUNCE   = 4,
    parameter int REPEAT_EN  = 0,
    parameter int REPEAT_DLY = 250,
    parameter int REPEAT_PER = 50
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_done,
    input  frame_res_t    fr_res,
    input  logic [CW-1:0] fr_code,
    output frame_res_t    stable_res,
    output logic [CW-1:0] stable_code,
    output logic          held,
    output logic          pulse
);

    localparam int MW   = $clog2(DEBOUNCE + 1);
    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RCW  = $clog2(RMAX + 1);

    frame_res_t     prev_res;
    logic [CW-1:0]  prev_code;
    logic [MW-1:0]  match_cnt;
    logic [MW-1:0]  match_next;
    logic [RCW-1:0] rep_cnt;
    logic [RCW-1:0] rep_next;
    logic           rep_phase;
    logic           ghost;
    logic           same;
    logic           changed;
    logic           rep_fire;

    always_comb begin
        same       = (fr_res == prev_res) && (fr_res != FR_SINGLE || fr_code == prev_code);
        match_next = !same ? MW'(1)
                   : (match_cnt == MW'(DEBOUNCE)) ? match_cnt : match_cnt + MW'(1);
        changed    = (match_next == MW'(DEBOUNCE)) &&
                     ((fr_res != stable_res) || (fr_res == FR_SINGLE && fr_code != stable_code));
        rep_next   = rep_cnt + RCW'(1);
        rep_fire   = (REPEAT_EN != 0) && held &&
                     (rep_next == (rep_phase ? RCW'(REPEAT_PER) : RCW'(REPEAT_DLY)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_res    <= FR_NONE;
            prev_code   <= CW'(NO_KEY);
            match_cnt   <= '0;
            stable_res  <= FR_NONE;
            stable_code <= CW'(NO_KEY);
            held        <= 1'b0;
            ghost       <= 1'b0;
            rep_cnt     <= '0;
            rep_phase   <= 1'b0;
            pulse       <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (frame_done) begin
                prev_res  <= fr_res;
                prev_code <= fr_code;
                match_cnt <= match_next;
                if (changed) begin
                    stable_res  <= fr_res;
                    stable_code <= (fr_res == FR_SINGLE) ? fr_code : CW'(NO_KEY);
                    rep_cnt     <= '0;
                    rep_phase   <= 1'b0;
                    case (fr_res)
                        // A single key that emerges from a multi-key state may be a ghost.
                        FR_SINGLE: begin
                            held  <= !ghost;
                            pulse <= !ghost;
                        end
                        FR_MULTI: begin
                            held  <= 1'b0;
                            ghost <= 1'b1;
                        end
                        default: begin
                            held  <= 1'b0;
                            ghost <= 1'b0;
                        end
                    endcase
                end else if (rep_fire) begin
                    pulse     <= 1'b1;
                    rep_cnt   <= '0;
                    rep_phase <= 1'b1;
                end else if (held && REPEAT_EN != 0) begin
                    rep_cnt <= rep_next;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_scan_decoder.sv
// Row-scanned matrix keypad controller: drives rows low one at a time, samples
// synchronised columns, classifies each frame and emits debounced key codes.
module keypad_scan_decoder
    import keypad_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 3,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 4,
    parameter int LEGACY_MAP = 1,
    parameter int REPEAT_EN  = 0,
    parameter int REPEAT_DLY = 250,
    parameter int REPEAT_PER = 50,
    localparam int NO_KEY    = no_key(ROWS, COLS),
    localparam int CW        = code_width(ROWS, COLS)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [ROWS-1:0] row_drv_n,
    input  logic [COLS-1:0] col_in_n,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_held,
    output logic            multi_key
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [COLS-1:0] col_meta;
    logic [COLS-1:0] col_sync;
    logic [DW-1:0]   dwell_cnt;
    logic [RW-1:0]   row_idx;
    logic [1:0]      acc_hits;
    logic [CW-1:0]   acc_code;
    logic [1:0]      row_hits;
    logic [CW-1:0]   row_code;
    logic [2:0]      hit_sum;
    logic [1:0]      tot_hits;
    logic [CW-1:0]   sel_code;
    logic            sample_now;
    logic            last_row;
    logic            frame_done;
    frame_res_t      fr_res;
    logic [CW-1:0]   fr_code;
    frame_res_t      stable_res;
    logic [CW-1:0]   stable_code;
    logic            held;
    logic            pulse;

    function automatic logic [CW-1:0] code_of(input int r, input int c);
        if (LEGACY_MAP != 0) return CW'(legacy_code(r, c, ROWS, COLS));
        return CW'(r * COLS + c);
    endfunction

    assign sample_now = (dwell_cnt == DW'(SCAN_DIV - 1));
    assign last_row   = (row_idx == RW'(ROWS - 1));

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        row_hits = 2'd0;
        row_code = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!col_sync[c]) begin
                row_code = code_of(int'(row_idx), c);
                if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
            end
        end
        hit_sum  = {1'b0, acc_hits} + {1'b0, row_hits};
        tot_hits = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
        sel_code = (row_hits != 2'd0) ? row_code : acc_code;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the two synchroniser flops depend on this.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta   <= '1;
            col_sync   <= '1;
            dwell_cnt  <= '0;
            row_idx    <= '0;
            row_drv_n  <= ~ROWS'(1);
            acc_hits   <= 2'd0;
            acc_code   <= '0;
            frame_done <= 1'b0;
            fr_res     <= FR_NONE;
            fr_code    <= CW'(NO_KEY);
        end else begin
            col_meta   <= col_in_n;
            col_sync   <= col_meta;
            frame_done <= 1'b0;
            if (sample_now) begin
                dwell_cnt <= '0;
                if (last_row) begin
                    row_idx    <= '0;
                    row_drv_n  <= ~ROWS'(1);
                    acc_hits   <= 2'd0;
                    acc_code   <= '0;
                    frame_done <= 1'b1;
                    fr_code    <= sel_code;
                    fr_res     <= (tot_hits == 2'd0) ? FR_NONE
                                : (tot_hits == 2'd1) ? FR_SINGLE : FR_MULTI;
                end else begin
                    row_idx   <= row_idx + RW'(1);
                    row_drv_n <= ~(ROWS'(1) << (row_idx + RW'(1)));
                    acc_hits  <= tot_hits;
                    acc_code  <= sel_code;
                end
            end else begin
                dwell_cnt <= dwell_cnt + DW'(1);
            end
        end
    end

    keypad_frame_debounce #(
        .CW         (CW),
        .NO_KEY     (NO_KEY),
        .DEBOUNCE   (DEBOUNCE),
        .REPEAT_EN  (REPEAT_EN),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .frame_done  (frame_done),
        .fr_res      (fr_res),
        .fr_code     (fr_code),
        .stable_res  (stable_res),
        .stable_code (stable_code),
        .held        (held),
        .pulse       (pulse)
    );

    // Outputs all register on the same edge so key_code is settled whenever key_valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code  <= CW'(NO_KEY);
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            key_code  <= held ? stable_code : CW'(NO_KEY);
            key_valid <= pulse;
            key_held  <= held;
            multi_key <= (stable_res == FR_MULTI);
        end
    end

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Scoreboard bench for keypad_scan_decoder: dut_a uses the phone map without
// repeat, dut_b the linear map with fast auto-repeat; each runs while the other is in reset.
module tb_keypad_scan_decoder;

    localparam int FRAME  = 32;
    localparam int NO_KEY = 12;

    typedef struct {
        logic [3:0] code;
        int         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic [3:0] row_a, row_b;
    logic [2:0] col_a, col_b;
    logic [3:0] code_a, code_b;
    logic       valid_a, valid_b, held_a, held_b, multi_a, multi_b;
    logic [3:0][2:0] keys;

    exp_t q_a[$];
    exp_t q_b[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   pulses_a = 0;
    int   pulses_b = 0;
    int   last_b = 0;
    logic prev_va = 1'b0;
    logic prev_vb = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keypad_scan_decoder #(
        .ROWS(4), .COLS(3), .SCAN_DIV(8), .DEBOUNCE(3), .LEGACY_MAP(1),
        .REPEAT_EN(0), .REPEAT_DLY(250), .REPEAT_PER(50)
    ) dut_a (
        .clk(clk), .rst(rst_a), .row_drv_n(row_a), .col_in_n(col_a),
        .key_code(code_a), .key_valid(valid_a), .key_held(held_a), .multi_key(multi_a)
    );

    keypad_scan_decoder #(
        .ROWS(4), .COLS(3), .SCAN_DIV(8), .DEBOUNCE(3), .LEGACY_MAP(0),
        .REPEAT_EN(1), .REPEAT_DLY(4), .REPEAT_PER(2)
    ) dut_b (
        .clk(clk), .rst(rst_b), .row_drv_n(row_b), .col_in_n(col_b),
        .key_code(code_b), .key_valid(valid_b), .key_held(held_b), .multi_key(multi_b)
    );

    // Passive keypad: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col_a = 3'b111;
        col_b = 3'b111;
        for (int r = 0; r < 4; r++) begin
            if (!row_a[r]) col_a = col_a & ~keys[r];
            if (!row_b[r]) col_b = col_b & ~keys[r];
        end
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic frames(input int n);
        repeat (n * FRAME) @(posedge clk);
    endtask

    task automatic push_a(input int code);
        q_a.push_back('{code: 4'(code), gap: 0});
    endtask

    task automatic push_b(input int code, input int gap);
        q_b.push_back('{code: 4'(code), gap: gap});
    endtask

    // Monitors: pop one expectation per key_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_a) begin
            check("a_one_row_low", $countones(~row_a), 1);
            if (valid_a) begin
                pulses_a++;
                check("a_valid_one_cycle", int'(prev_va), 0);
                check("a_pulse_expected", int'(q_a.size() > 0), 1);
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    check("a_pulse_code", int'(code_a), int'(e.code));
                end
            end
        end
        prev_va = valid_a;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_b) begin
            check("b_one_row_low", $countones(~row_b), 1);
            if (valid_b) begin
                pulses_b++;
                check("b_valid_one_cycle", int'(prev_vb), 0);
                check("b_pulse_expected", int'(q_b.size() > 0), 1);
                if (q_b.size() > 0) begin
                    e = q_b.pop_front();
                    check("b_pulse_code", int'(code_b), int'(e.code));
                    if (e.gap > 0) check("b_pulse_gap_cycles", cyc - last_b, e.gap * FRAME);
                end
                last_b = cyc;
            end
        end
        prev_vb = valid_b;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int tbl_r[3]    = '{3, 3, 3};
        int tbl_c[3]    = '{0, 1, 2};
        int tbl_code[3] = '{10, 0, 11};

        keys  = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("a_reset_rows", int'(row_a), 4'b1110);
        check("a_reset_code", int'(code_a), NO_KEY);
        check("a_reset_valid", int'(valid_a), 0);
        check("a_reset_held", int'(held_a), 0);
        check("a_reset_multi", int'(multi_a), 0);
        rst_a = 1'b0;
        frames(5);
        check("a_idle_no_pulse", pulses_a, 0);

        // Single press of '2' (row0/col1), then release.
        push_a(2);
        keys[0][1] = 1'b1;
        frames(5);
        check("a_press2_code", int'(code_a), 2);
        check("a_press2_held", int'(held_a), 1);
        check("a_press2_pulses", pulses_a, 1);
        keys = '0;
        frames(5);
        check("a_release_code", int'(code_a), NO_KEY);
        check("a_release_held", int'(held_a), 0);
        check("a_release_no_pulse", pulses_a, 1);

        // Reset in the middle of a hold, then re-acceptance with fresh frames.
        push_a(2);
        keys[0][1] = 1'b1;
        frames(5);
        check("a_hold_before_reset", int'(held_a), 1);
        @(posedge clk);
        #3 rst_a = 1'b1;
        #1;
        check("a_midrst_rows", int'(row_a), 4'b1110);
        check("a_midrst_code", int'(code_a), NO_KEY);
        check("a_midrst_valid", int'(valid_a), 0);
        check("a_midrst_held", int'(held_a), 0);
        check("a_midrst_multi", int'(multi_a), 0);
        #20 rst_a = 1'b0;
        p = pulses_a;
        frames(1);
        check("a_no_pulse_on_deassert", pulses_a, p);
        push_a(2);
        frames(5);
        check("a_reaccept_held", int'(held_a), 1);
        check("a_reaccept_code", int'(code_a), 2);
        check("a_reaccept_pulses", pulses_a, p + 1);
        keys = '0;
        frames(5);

        // Bottom row: '*', '0', '#'.
        for (int i = 0; i < 3; i++) begin
            push_a(tbl_code[i]);
            keys[tbl_r[i]][tbl_c[i]] = 1'b1;
            frames(5);
            check("a_row3_code", int'(code_a), tbl_code[i]);
            check("a_row3_held", int'(held_a), 1);
            keys = '0;
            frames(5);
            check("a_row3_queue_empty", q_a.size(), 0);
        end

        // Bounce on alternate frames must not be accepted; steady hold gives one pulse.
        p = pulses_a;
        for (int i = 0; i < 4; i++) begin
            keys[0][1] = 1'b1;
            frames(1);
            keys = '0;
            frames(1);
        end
        check("a_bounce_no_pulse", pulses_a, p);
        keys[0][1] = 1'b1;
        repeat (2 * FRAME - 4) @(posedge clk);
        check("a_bounce_no_early_pulse", pulses_a, p);
        push_a(2);
        frames(4);
        check("a_bounce_one_pulse", pulses_a, p + 1);
        check("a_bounce_code", int'(code_a), 2);
        keys = '0;
        frames(5);

        // Multi-key with ghost guard.
        p = pulses_a;
        keys[0][0] = 1'b1;
        keys[1][1] = 1'b1;
        frames(5);
        check("a_multi_flag", int'(multi_a), 1);
        check("a_multi_code", int'(code_a), NO_KEY);
        check("a_multi_held", int'(held_a), 0);
        keys[1][1] = 1'b0;
        frames(5);
        check("a_ghost_multi", int'(multi_a), 0);
        check("a_ghost_held", int'(held_a), 0);
        check("a_ghost_code", int'(code_a), NO_KEY);
        check("a_ghost_no_pulse", pulses_a, p);
        keys = '0;
        frames(5);
        push_a(5);
        keys[1][1] = 1'b1;
        frames(5);
        check("a_after_none_code", int'(code_a), 5);
        check("a_after_none_held", int'(held_a), 1);
        check("a_after_none_pulses", pulses_a, p + 1);
        keys = '0;
        frames(5);
        check("a_final_queue_empty", q_a.size(), 0);

        // Linear map and auto-repeat on dut_b. The release is itself debounced,
        // so one more repeat lands at +14 frames before the state drops to NONE.
        rst_a = 1'b1;
        #7 rst_b = 1'b0;
        frames(2);
        push_b(9, 0);
        push_b(9, 4);
        for (int i = 0; i < 5; i++) push_b(9, 2);
        p = pulses_b;
        keys[3][0] = 1'b1;
        for (int i = 0; i < 10 * FRAME && pulses_b == p; i++) @(posedge clk);
        check("b_accept_seen", int'(pulses_b != p), 1);
        #1;
        check("b_linear_code", int'(code_b), 9);
        check("b_held", int'(held_b), 1);
        repeat (12 * FRAME + 16) @(posedge clk);
        keys = '0;
        frames(6);
        check("b_pulse_total", pulses_b, p + 7);
        check("b_queue_empty", q_b.size(), 0);
        check("b_release_held", int'(held_b), 0);
        check("b_release_code", int'(code_b), NO_KEY);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
